// File: rtl/mm_nibble_accumulator_if.sv
// Term/result handshake and external 4-bit adder hookup for mm_nibble_accumulator.
interface mm_nibble_accumulator_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             overflow;
  logic             busy;
  logic [3:0]       adder_a;
  logic [3:0]       adder_b;
  logic             adder_cin;
  logic [3:0]       adder_s;
  logic             adder_cout;

  modport slave (
    input  in_valid, in_data, in_last, out_ready, adder_s, adder_cout,
    output in_ready, out_valid, sum, overflow, busy, adder_a, adder_b, adder_cin
  );

  modport master (
    output in_valid, in_data, in_last, out_ready, adder_s, adder_cout,
    input  in_ready, out_valid, sum, overflow, busy, adder_a, adder_b, adder_cin
  );
endinterface

// File: rtl/mm_nibble_accumulator.sv
// Dot-product accumulator that adds WIDTH-bit terms one nibble per cycle
// through a shared external 4-bit adder, with a registered carry chain.
module mm_nibble_accumulator #(
  parameter int WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  mm_nibble_accumulator_if.slave      bus
);
  localparam int NIB = WIDTH / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] term;
  logic [KW-1:0]    k;
  logic [KW-1:0]    k_next;
  logic             last_r;
  logic             overflow_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;
  logic [3:0]       adder_a_r;
  logic [3:0]       adder_b_r;
  logic             carry;
  logic [3:0]       acc_nib_next;
  logic [3:0]       term_nib_next;

  // Operands are registered one cycle ahead: the next nibble of acc is
  // untouched by the current add, so it can be loaded alongside the write-back.
  always_comb begin
    k_next        = k + 1'b1;
    acc_nib_next  = acc[4*k_next +: 4];
    term_nib_next = term[4*k_next +: 4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      term        <= '0;
      k           <= '0;
      last_r      <= 1'b0;
      overflow_r  <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      adder_a_r   <= '0;
      adder_b_r   <= '0;
      carry       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            term       <= bus.in_data;
            last_r     <= bus.in_last;
            k          <= '0;
            carry      <= 1'b0;
            adder_a_r  <= acc[3:0];
            adder_b_r  <= bus.in_data[3:0];
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state      <= ADD;
          end
        end

        ADD: begin
          acc[4*k +: 4] <= bus.adder_s;
          if (k == KW'(NIB - 1)) begin
            if (bus.adder_cout)
              overflow_r <= 1'b1;
            k         <= '0;
            carry     <= 1'b0;
            adder_a_r <= '0;
            adder_b_r <= '0;
            busy_r    <= 1'b0;
            if (last_r) begin
              out_valid_r <= 1'b1;
              state       <= DONE;
            end else begin
              in_ready_r <= 1'b1;
              state      <= IDLE;
            end
          end else begin
            k         <= k_next;
            carry     <= bus.adder_cout;
            adder_a_r <= acc_nib_next;
            adder_b_r <= term_nib_next;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            acc         <= '0;
            overflow_r  <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.sum       = acc;
  assign bus.overflow  = overflow_r;
  assign bus.adder_a   = adder_a_r;
  assign bus.adder_b   = adder_b_r;
  assign bus.adder_cin = carry;
endmodule

// File: doc/mm_nibble_accumulator.md
# mm_nibble_accumulator

Sequencer that time-shares one external 4-bit ripple-carry adder to accumulate a stream of WIDTH-bit terms into a WIDTH-bit sum, one nibble per cycle with a registered carry chain. It sits in the matrix-multiplication datapath as the dot-product accumulator: each accepted term is added to the running sum, and a term flagged `in_last` ends the result. The adder itself stays combinational and outside this block; this block drives its operands and carry-in and captures its sum and carry-out.

## Interface
- WIDTH, 16, accumulator and term width; must be a multiple of 4.
- NIB, WIDTH/4, nibbles per term (derived, not overridden).

- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  term available.
- in_ready  out  1  block can accept a term this cycle.
- in_data  in  WIDTH  term value, unsigned.
- in_last  in  1  term is the final one of the current sum.
- out_valid  out  1  result held on `sum`/`overflow`.
- out_ready  in  1  consumer takes the result.
- sum  out  WIDTH  accumulated result, modulo 2^WIDTH.
- overflow  out  1  sticky; set if any term's add produced carry out of bit WIDTH-1.
- busy  out  1  high in ADD state.
- adder_a  out  4  accumulator nibble to the adder.
- adder_b  out  4  term nibble to the adder.
- adder_cin  out  1  carry-in to the adder.
- adder_s  in  4  adder sum, combinational from adder_a/b/cin.
- adder_cout  in  1  adder carry-out.

## Operation
- States: IDLE, ADD, DONE.
- IDLE: in_ready=1. On in_valid: latch in_data into the term register and in_last into last_r; clear the nibble index k to 0 and the carry register to 0; go to ADD.
- ADD (NIB cycles, k=0..NIB-1): adder_a=acc[4k+3:4k], adder_b=term[4k+3:4k], adder_cin=carry (0 when k=0). At the clock edge acc[4k+3:4k]<=adder_s and carry<=adder_cout.
- At k=NIB-1: if adder_cout=1, overflow<=1. Then go to DONE if last_r is set, or to IDLE if it is not.
- DONE: out_valid=1, and sum and overflow stay stable. On out_ready: clear acc and overflow to 0 and go to IDLE.
- Outside ADD: adder_a, adder_b and adder_cin are driven to 0.
- in_valid is ignored outside IDLE. No term is dropped, because in_ready=0 in those states.
- sum is driven from acc at all times. Intermediate values during ADD are not valid results.
- in_last on the first term gives a single-term result equal to that term.

## Timing
- Reset: state=IDLE, acc=0, term=0, carry=0, k=0, overflow=0, last_r=0.
- Output values after reset: in_ready=1, out_valid=0, busy=0, sum=0, adder_a/b/cin=0.
- Term acceptance costs 1 cycle in IDLE followed by NIB cycles in ADD. Throughput is one term per NIB+1 cycles (5 for WIDTH=16).
- Latency from accepting the last term to out_valid=1 is NIB+1 edges.
- out_valid stays high with sum stable until out_ready is seen. In the cycle after out_ready, out_valid=0, sum=0 and in_ready=1.
- Reset asserted in any state, including mid-ADD, takes effect at the next edge. The partial sum is discarded and the adder operands return to 0.
- in_valid and out_ready asserted together in DONE: only the result handoff happens, and the term waits for IDLE.

## Test plan
- Reset, then one term 0x0002 with in_last=1 -> after 5 edges out_valid=1, sum=0x0002, overflow=0.
- Terms 0x00FF then 0x0001 (last) -> sum=0x0100, overflow=0. Check the carry propagates across nibbles 0→1→2 via adder_cin.
- Terms 0xFFFF then 0x0002 (last) -> sum=0x0001, overflow=1. Take the result, then send a single term 0x0003 (last) -> sum=0x0003, overflow=0.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid, sum and overflow stay constant, in_ready=0, and in_valid pulses are ignored.
- Assert rst at k=2 of an add of 0x1234 -> the next cycle shows in_ready=1, sum=0 and adder_a/b/cin=0. A following term 0x0005 (last) -> sum=0x0005.
- Drive in_valid continuously with 4 terms of 0x0001 (last on the 4th) -> in_ready is high 1 cycle in 5, and the final sum=0x0004.
